// File: rtl/a_row_loader_pkg.sv
// Shared types and helpers for the A-matrix row loader.
package a_loader_pkg;

  typedef enum logic [1:0] {LOAD, FLUSH, RUN, DONE} a_ld_state_t;

  // Shift window length: DIM cycles to fill the skew plus 2*DIM-2 to drain it.
  function automatic int run_len_default(input int dim);
    return 3 * dim - 2;
  endfunction

endpackage

// File: rtl/a_row_loader_if.sv
// Stream input and A-memory write/shift port of the row loader.
interface a_row_loader_if #(
  parameter int BITS_AB = 8,
  parameter int DIM     = 8
);

  localparam int ROW_W = $clog2(DIM);

  logic signed [BITS_AB-1:0]          in_data;
  logic                               in_valid;
  logic                               in_ready;
  logic signed [DIM-1:0][BITS_AB-1:0] Ain;
  logic        [ROW_W-1:0]            Arow;
  logic                               WrEn;
  logic                               en;
  logic                               busy;
  logic                               done;

  modport master (
    output in_data, in_valid,
    input  in_ready, Ain, Arow, WrEn, en, busy, done
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, Ain, Arow, WrEn, en, busy, done
  );

endinterface

// File: rtl/a_row_loader_assembler.sv
// Collects one row of DIM elements; row_vec already contains the element
// arriving on the completing transfer so the top can register it directly.
module a_row_assembler #(
  parameter int BITS_AB = 8,
  parameter int DIM     = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic signed [BITS_AB-1:0]   data,
  output logic                        row_complete,
  output logic [DIM-1:0][BITS_AB-1:0] row_vec
);

  localparam int COL_W = $clog2(DIM);

  logic [COL_W-1:0]            col;
  logic [DIM-1:0][BITS_AB-1:0] row_buf;

  // Store each accepted element in its column slot; col wraps after DIM-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      col     <= '0;
      row_buf <= '0;
    end else if (push) begin
      row_buf[col] <= data;
      col          <= col + 1'b1;
    end
  end

  // Flag the last column and merge the in-flight element into the row view.
  always_comb begin
    row_complete = push && (col == COL_W'(DIM - 1));
    row_vec      = row_buf;
    row_vec[col] = data;
  end

endmodule

// File: rtl/a_row_loader.sv
// A-side front end: streams rows into the skewing A memory, then runs the
// shift window once per matrix and pulses done.
module a_row_loader
  import a_loader_pkg::*;
#(
  parameter int BITS_AB = 8,
  parameter int DIM     = 8,
  parameter int RUN_LEN = run_len_default(DIM)
) (
  input logic         clk,
  input logic         rst,
  a_row_loader_if.slave bus
);

  localparam int ROW_W = $clog2(DIM);
  localparam int CNT_W = $clog2(RUN_LEN + 1);

  a_ld_state_t state, next_state;

  logic [ROW_W-1:0]            row;
  logic [CNT_W-1:0]            run_cnt;
  logic                        push;
  logic                        row_complete;
  logic                        last_run;
  logic [DIM-1:0][BITS_AB-1:0] row_vec;

  logic [DIM-1:0][BITS_AB-1:0] ain_q;
  logic [ROW_W-1:0]            arow_q;
  logic                        wren_q;
  logic                        en_q;
  logic                        done_q;

  assign bus.in_ready = (state == LOAD) && !rst;
  assign bus.busy     = (state != LOAD);
  assign bus.Ain      = ain_q;
  assign bus.Arow     = arow_q;
  assign bus.WrEn     = wren_q;
  assign bus.en       = en_q;
  assign bus.done     = done_q;

  assign push     = bus.in_valid && bus.in_ready;
  assign last_run = (run_cnt == CNT_W'(RUN_LEN - 1));

  a_row_assembler #(
    .BITS_AB (BITS_AB),
    .DIM     (DIM)
  ) u_assembler (
    .clk          (clk),
    .rst          (rst),
    .push         (push),
    .data         (bus.in_data),
    .row_complete (row_complete),
    .row_vec      (row_vec)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= next_state;
  end

  // Next-state decode: last row completes -> FLUSH -> RUN window -> DONE.
  always_comb begin
    next_state = state;
    case (state)
      LOAD:    if (row_complete && (row == ROW_W'(DIM - 1))) next_state = FLUSH;
      FLUSH:   next_state = RUN;
      RUN:     if (last_run) next_state = DONE;
      DONE:    next_state = LOAD;
      default: next_state = LOAD;
    endcase
  end

  // Row index advances per completed row and restarts for the next matrix.
  always_ff @(posedge clk) begin
    if (rst)                 row <= '0;
    else if (state == DONE)  row <= '0;
    else if (row_complete)   row <= row + 1'b1;
  end

  // Run counter only moves inside the shift window.
  always_ff @(posedge clk) begin
    if (rst)                run_cnt <= '0;
    else if (state == RUN)  run_cnt <= last_run ? '0 : run_cnt + 1'b1;
    else                    run_cnt <= '0;
  end

  // Registered outputs; en/done are registered from next_state so they line up with RUN/DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      ain_q  <= '0;
      arow_q <= '0;
      wren_q <= 1'b0;
      en_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      wren_q <= row_complete;
      if (row_complete) begin
        ain_q  <= row_vec;
        arow_q <= row;
      end
      en_q   <= (next_state == RUN);
      done_q <= (next_state == DONE);
    end
  end

endmodule
